// File: rtl/bus_master.sv
// bus_master: single-command burst master driving the memory slave's
// packed-field AR/R/AW/W/B bus.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_write/addr/len/id          command fields (len 0 is rejected with err)
//   wd_valid/wd_ready/wd_data      requester write stream (passed through to W)
//   rd_valid/rd_data/rd_err/rd_last  registered read beats toward the requester
//   done/done_err                  one-cycle completion pulse and burst error
//   ARVALID/AR/ARREADY             read address {addr, len, id}
//   RVALID/RLAST/RDATA/RREADY      read data {data, err}
//   AWVALID/AW/AWREADY             write address {addr, id}
//   WVALID/WLAST/WDATA/WREADY      write data (combinational pass-through)
//   BVALID/BRESP/BREADY            write response {err, id}
//
// Build option: BUS_MASTER_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on
// every bus phase; without it the master waits indefinitely.
`timescale 1ns/1ps
module bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [3:0]  cmd_id,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [7:0]  wd_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        rd_err,
  output logic        rd_last,
  output logic        done,
  output logic        done_err,
  output logic        ARVALID,
  output logic [15:0] AR,
  input  logic        ARREADY,
  input  logic        RVALID,
  input  logic        RLAST,
  input  logic [8:0]  RDATA,
  output logic        RREADY,
  output logic        AWVALID,
  output logic [11:0] AW,
  input  logic        AWREADY,
  output logic        WVALID,
  output logic        WLAST,
  output logic [7:0]  WDATA,
  input  logic        WREADY,
  input  logic        BVALID,
  input  logic [4:0]  BRESP,
  output logic        BREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t      state, state_next;
  logic [7:0]  addr_q;
  logic [3:0]  len_q;
  logic [3:0]  id_q;
  logic [3:0]  beat_q;
  logic        err_q;

  logic accept;
  logic at_last;
  logic r_beat;
  logic r_end;
  logic w_beat;
  logic b_hs;
  logic timeout;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("bus_master: TIMEOUT_CYCLES must be nonzero");
  end

  assign accept  = (state == S_IDLE) && cmd_valid && cmd_ready;
  assign at_last = (beat_q == len_q - 4'd1);
  assign r_beat  = (state == S_R) && RVALID && RREADY;
  assign r_end   = r_beat && (RLAST || at_last);
  assign w_beat  = WVALID && WREADY;
  assign b_hs    = (state == S_B) && BVALID && BREADY;

  // W phase is a straight pass-through, gated by state so every bus output
  // is zero outside W and drops the instant reset forces IDLE.
  assign WVALID   = (state == S_W) && wd_valid;
  assign WDATA    = (state == S_W) ? wd_data : '0;
  assign wd_ready = (state == S_W) && WREADY;
  assign WLAST    = WVALID && at_last;

  // Address buses are the latched command fields themselves.
  assign AR = {addr_q, len_q, id_q};
  assign AW = {addr_q, id_q};

`ifdef BUS_MASTER_TIMEOUT_EN
  logic [15:0] wdog_q;
  logic        bus_phase;

  assign bus_phase = state inside {S_AR, S_R, S_AW, S_W, S_B};
  assign timeout   = bus_phase && (wdog_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (!bus_phase || (state_next != state) || r_beat || w_beat) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (accept) begin
        state_next = (cmd_len == '0) ? S_DONE : (cmd_write ? S_AW : S_AR);
      end
      S_AR:   if (ARVALID && ARREADY)     state_next = S_R;
      S_R:    if (r_end)                  state_next = S_DONE;
      S_AW:   if (AWVALID && AWREADY)     state_next = S_W;
      S_W:    if (w_beat && at_last)      state_next = S_B;
      S_B:    if (b_hs)                   state_next = S_DONE;
      S_DONE:                             state_next = S_IDLE;
      default:                            state_next = S_IDLE;
    endcase
    if (timeout) state_next = S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      cmd_ready <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWVALID   <= 1'b0;
      BREADY    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
    end else begin
      state <= state_next;

      if (accept) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        id_q   <= cmd_id;
        beat_q <= '0;
      end else if (r_beat || w_beat) begin
        beat_q <= beat_q + 4'd1;
      end

      if (accept) begin
        err_q <= (cmd_len == '0);
      end else begin
        // RLAST must coincide exactly with the len-th beat.
        if (r_beat && (RDATA[0] || (RLAST != at_last))) err_q <= 1'b1;
        if (b_hs && (BRESP[4] || (BRESP[3:0] != id_q))) err_q <= 1'b1;
        if (timeout) err_q <= 1'b1;
      end

      // Registered from the state entered at this edge; the completion
      // pulse trails the DONE state by one cycle, and cmd_ready one more.
      cmd_ready <= (state == S_IDLE) && !accept;
      ARVALID   <= (state_next == S_AR);
      RREADY    <= (state_next == S_R);
      AWVALID   <= (state_next == S_AW);
      BREADY    <= (state_next == S_B);

      rd_valid <= r_beat;
      rd_last  <= r_end;
      if (r_beat) begin
        rd_data <= RDATA[8:1];
        rd_err  <= RDATA[0];
      end

      done     <= (state == S_DONE);
      done_err <= (state == S_DONE) && err_q;
    end
  end

endmodule

// File: tb/tb_bus_master.sv
`timescale 1ns/1ps
module tb_bus_master;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 64;
`endif
  localparam bit STALLS = (TO > 16);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_len, cmd_id;
  logic        wd_valid, wd_ready;
  logic [7:0]  wd_data;
  logic        rd_valid, rd_err, rd_last, done, done_err;
  logic [7:0]  rd_data;
  logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
  logic [15:0] AR;
  logic [8:0]  RDATA;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic [11:0] AW;
  logic [7:0]  WDATA;
  logic [4:0]  BRESP;

  always #5 clk = ~clk;

  bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .rd_last(rd_last),
    .done(done), .done_err(done_err),
    .ARVALID(ARVALID), .AR(AR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RLAST(RLAST), .RDATA(RDATA), .RREADY(RREADY),
    .AWVALID(AWVALID), .AW(AW), .AWREADY(AWREADY),
    .WVALID(WVALID), .WLAST(WLAST), .WDATA(WDATA), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY)
  );

  int unsigned checks = 0, errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment state: slave storage, reference memory, per-command knobs.
  logic [7:0]  smem    [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  wdat    [16];
  int          cur_kind;            // 0 no bus traffic, 1 read, 2 write
  logic [15:0] exp_ar;
  logic [11:0] exp_aw;
  int          s_len, s_rlast_at, s_err_beat;
  logic [4:0]  s_bresp;
  bit          s_fast, s_ar_hold;

  logic [9:0]  exp_rd   [$];        // {data, err, last}
  logic        exp_done [$];
  int unsigned rd_total = 0, done_total = 0, done_edge = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({cmd_ready, wd_ready, rd_valid, rd_data, rd_err, rd_last, done, done_err,
                ARVALID, AR, RREADY, AWVALID, AW, WVALID, WLAST, WDATA, BREADY});
  endfunction

  // Monitor: pops expectations whenever the DUT presents a beat or completion.
  initial begin : monitor
    logic [9:0] e;
    logic       ed;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        rd_total++;
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: actual=beat 0x%0h required=no beat", rd_data);
        end else begin
          e = exp_rd.pop_front();
          check("rd_data", rd_data, e[9:2]);
          check("rd_err",  rd_err,  e[1]);
          check("rd_last", rd_last, e[0]);
        end
      end
      if (done) begin
        done_total++;
        done_edge = cyc;
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: actual=done pulse required=none");
        end else begin
          ed = exp_done.pop_front();
          check("done_err", done_err, ed);
        end
      end
    end
  end

  // Slave plus write-data requester; everything driven at negedge.
  initial begin : slave
    int         hold, n, guard;
    logic [7:0] base;
    ARREADY = 0; RVALID = 0; RLAST = 0; RDATA = '0; AWREADY = 0; WREADY = 0;
    BVALID = 0; BRESP = '0; wd_valid = 0; wd_data = '0;
    forever begin
      @(negedge clk);
      if (ARVALID) begin
        check("ar_fields", AR, exp_ar);
        check("ar_on_read", cur_kind, 1);
        base = AR[15:8];
        if (s_ar_hold) begin
          hold = 0;
          while (ARVALID && hold < 100) begin @(negedge clk); hold++; end
          check("wdog_ar_cycles", hold, TO);
        end else begin
          repeat ((s_fast || !STALLS) ? 0 : $urandom_range(0, 3)) @(negedge clk);
          ARREADY = 1; @(negedge clk); ARREADY = 0;
          check("ar_to_r", {ARVALID, RREADY}, 2'b01);
          for (int b = 1; b <= 16; b++) begin
            if (!s_fast && STALLS) repeat ($urandom_range(0, 2)) @(negedge clk);
            if (!RREADY) break;
            RVALID = 1;
            RDATA  = {smem[8'(base + b - 1)], b == s_err_beat};
            RLAST  = (b == s_rlast_at);
            @(negedge clk);
            RVALID = 0; RLAST = 0;
          end
        end
      end else if (AWVALID) begin
        check("aw_fields", AW, exp_aw);
        check("aw_on_write", cur_kind, 2);
        base = AW[11:4];
        repeat (STALLS ? $urandom_range(0, 3) : 0) @(negedge clk);
        AWREADY = 1; @(negedge clk); AWREADY = 0;
        check("aw_to_w", AWVALID, 0);
        n = 0; guard = 0;
        while (!BREADY && guard < 200) begin
          wd_valid = (n < s_len) && (!STALLS || $urandom_range(0, 3) != 0);
          wd_data  = (n < s_len) ? wdat[n] : 8'($urandom);
          WREADY   = !STALLS || ($urandom_range(0, 3) != 0);
          #1;
          check("wvalid_pass", WVALID, wd_valid);
          check("wd_ready_pass", wd_ready, WREADY);
          if (WVALID && WREADY && n < 16) begin
            check("wdata", WDATA, wdat[n]);
            check("wlast", WLAST, n == s_len - 1);
            smem[8'(base + n)] = WDATA;
            n++;
          end
          @(negedge clk); guard++;
        end
        wd_valid = 0; WREADY = 0;
        check("w_beats", n, s_len);
        repeat (STALLS ? $urandom_range(0, 3) : 0) @(negedge clk);
        BVALID = 1; BRESP = s_bresp; @(negedge clk); BVALID = 0;
        check("b_to_done", BREADY, 0);
      end
    end
  end

  // Issues one command, pushes the expected outcome, waits for completion.
  task automatic run_cmd(input bit wr, input logic [7:0] a, input logic [3:0] l,
                         input logic [3:0] id, input int rlast_at, input int err_beat,
                         input logic [4:0] bresp, input bit fast, output int lat);
    int          n, guard;
    bit          e;
    int unsigned acc, d0;
    s_len = l; s_rlast_at = rlast_at; s_err_beat = err_beat; s_bresp = bresp; s_fast = fast;
    if (l == 0) begin
      cur_kind = 0; e = 1;
    end else if (wr) begin
      cur_kind = 2; exp_aw = {a, id};
      for (int i = 0; i < l; i++) ref_mem[8'(a + i)] = wdat[i];
      e = bresp[4] || (bresp[3:0] != id);
    end else if (s_ar_hold) begin
      cur_kind = 1; exp_ar = {a, l, id}; e = 1;
    end else begin
      cur_kind = 1; exp_ar = {a, l, id};
      n = (rlast_at >= 1 && rlast_at < l) ? rlast_at : l;
      for (int i = 1; i <= n; i++)
        exp_rd.push_back({ref_mem[8'(a + i - 1)], i == err_beat, i == n});
      e = (rlast_at != l) || (err_beat >= 1 && err_beat <= n);
    end
    exp_done.push_back(e);

    guard = 0;
    while (!cmd_ready && guard < 50) begin @(negedge clk); guard++; end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_id = id;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = 8'($urandom); cmd_len = 4'($urandom); cmd_id = 4'($urandom);
    acc = cyc;
    check("cmd_ready_busy", cmd_ready, 0);
    d0 = done_total; guard = 0;
    while (done_total == d0 && guard < 600) begin @(negedge clk); #1; guard++; end
    if (done_total == d0) begin
      checks++; errors++;
      $display("FAIL done_timeout: actual=no done required=done within 600 cycles");
      lat = -1;
    end else begin
      lat = int'(done_edge - acc);
      check("ready_during_done", cmd_ready, 0);
      check("rd_drained", exp_rd.size(), 0);
      @(negedge clk);
      check("ready_after_done", cmd_ready, 1);
    end
  endtask

  initial begin : stim
    int          lat, guard, r, rl, eb;
    int unsigned r0, d0;
    logic [3:0]  l, id;
    logic [4:0]  br;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    s_ar_hold = 0; s_fast = 0; cur_kind = 0; s_len = 0; s_rlast_at = 0; s_err_beat = 0;
    s_bresp = '0; exp_ar = '0; exp_aw = '0;
    for (int i = 0; i < 256; i++) begin smem[i] = 8'($urandom); ref_mem[i] = smem[i]; end

    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Write 0x11/0x22/0x33 to 0x01..0x03, then read it back.
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
    run_cmd(1, 8'h01, 4'd3, 4'h5, 0, 0, 5'h05, 0, lat);
    check("slave_mem1", smem[1], 8'h11);
    check("slave_mem2", smem[2], 8'h22);
    check("slave_mem3", smem[3], 8'h33);
    run_cmd(0, 8'h01, 4'd3, 4'h5, 3, 0, 5'h00, 0, lat);

    run_cmd(0, 8'h77, 4'd0, 4'h2, 0, 0, 5'h00, 0, lat);
    check("zero_len_latency", lat, 1);

    wdat[0] = 8'hA5; wdat[1] = 8'h5A;
    run_cmd(1, 8'h40, 4'd2, 4'h3, 0, 0, 5'h14, 0, lat);

    run_cmd(0, 8'h10, 4'd1, 4'h9, 1, 0, 5'h00, 1, lat);
    check("min_read_latency", lat, 3);

    run_cmd(0, 8'h20, 4'd4, 4'h2, 2, 0, 5'h00, 0, lat);   // early RLAST
    run_cmd(0, 8'h20, 4'd4, 4'h2, 0, 0, 5'h00, 0, lat);   // no RLAST
    run_cmd(0, 8'h20, 4'd4, 4'h2, 4, 3, 5'h00, 0, lat);   // beat error
    run_cmd(0, 8'hFE, 4'd15, 4'hF, 15, 0, 5'h00, 0, lat); // max len, wrapping

    // Reset while beat 2 of a 4-beat read is on the bus.
    s_len = 4; s_rlast_at = 4; s_err_beat = 0; s_fast = 1; cur_kind = 1;
    exp_ar = {8'h50, 4'd4, 4'h6};
    exp_rd.push_back({ref_mem[8'h50], 1'b0, 1'b0});
    r0 = rd_total; d0 = done_total;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h50; cmd_len = 4'd4; cmd_id = 4'h6;
    @(negedge clk);
    cmd_valid = 0;
    guard = 0;
    while (rd_total == r0 && guard < 50) begin @(negedge clk); #1; guard++; end
    check("rst_beat1_seen", rd_total, r0 + 1);
    check("rst_beat2_on_bus", {RVALID, RREADY}, 2'b11);
    rst_n = 0;
    #1;
    check("reset_mid_burst", outs(), 0);
    exp_rd.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (8) @(negedge clk);
    check("no_done_after_reset", done_total, d0);
    s_fast = 0;
    run_cmd(0, 8'h01, 4'd3, 4'h5, 3, 0, 5'h00, 0, lat);

    for (int t = 0; t < 40; t++) begin
      l  = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      id = 4'($urandom);
      r  = $urandom_range(0, 7);
      rl = (r == 0) ? 0 : ((r == 1 && l > 1) ? $urandom_range(1, l - 1) : int'(l));
      eb = (l > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, l) : 0;
      r  = $urandom_range(0, 5);
      br = (r == 0) ? {1'b1, id} : ((r == 1) ? {1'b0, id ^ 4'h1} : {1'b0, id});
      for (int i = 0; i < 16; i++) wdat[i] = 8'($urandom);
      run_cmd(bit'($urandom_range(0, 1)), 8'($urandom), l, id, rl, eb, br, 0, lat);
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    s_ar_hold = 1;
    run_cmd(0, 8'h30, 4'd2, 4'h1, 2, 0, 5'h00, 0, lat);
    s_ar_hold = 0;
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : time_limit
    #500000;
    $display("FAIL sim_time_limit: actual=still running required=finished");
    $fatal(1, "time limit");
  end

endmodule
